// File: rtl/ac_writeback_ctrl.sv
// Accumulator register and command sequencer wrapped around the combinational ALU.
// Optional macro DIV0_TRAP_EN builds a TRAP state that catches divide/mod by zero.
`timescale 1ns/1ps

module ac_writeback_ctrl #(
  parameter int                DATA_W = 16,
  parameter logic [DATA_W-1:0] AC_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_operand,
  input  logic              ac_clr,
  input  logic              err_clr,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_in_bus,
  output logic [DATA_W-1:0] alu_in_ac,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] ac_out,
  output logic              done,
  output logic              zero,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for a command or ac_clr
  // EXEC  | ALU settling on registered operands; write-back on next edge
  // TRAP  | divide/mod by zero caught, waiting for err_clr
`ifdef DIV0_TRAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, TRAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] ac_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] bus_q;
  logic              done_q;
  logic              zero_q;
  logic              div0;
  logic [DATA_W-1:0] wb_val;

  assign div0 = ((op_q == 3'd4) || (op_q == 3'd5)) && (bus_q == '0);

  always_comb begin
    wb_val = alu_result;
`ifndef DIV0_TRAP_EN
    // The ALU output is undefined for a zero divisor, so substitute fixed results.
    if (div0) begin
      if (op_q == 3'd4) wb_val = {DATA_W{1'b1}};
      else              wb_val = ac_q;
    end
`endif
  end

`ifdef DIV0_TRAP_EN
  logic err_q;
  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ac_q    <= AC_RST;
      op_q    <= '0;
      bus_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= (AC_RST == '0);
`ifdef DIV0_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ac_clr) begin
            ac_q   <= AC_RST;
            zero_q <= (AC_RST == '0);
          end else if (cmd_valid) begin
            op_q    <= cmd_op;
            bus_q   <= cmd_operand;
            state_q <= EXEC;
          end
        end
        EXEC: begin
`ifdef DIV0_TRAP_EN
          if (div0) begin
            err_q   <= 1'b1;
            state_q <= TRAP;
          end else begin
            ac_q    <= wb_val;
            zero_q  <= (wb_val == '0);
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
`else
          ac_q    <= wb_val;
          zero_q  <= (wb_val == '0);
          done_q  <= 1'b1;
          state_q <= IDLE;
`endif
        end
`ifdef DIV0_TRAP_EN
        TRAP: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == IDLE) && !ac_clr;
  assign alu_op     = op_q;
  assign alu_in_bus = bus_q;
  assign alu_in_ac  = ac_q;
  assign ac_out     = ac_q;
  assign done       = done_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_ac_writeback_ctrl.sv
// Self-checking bench for ac_writeback_ctrl: behavioural ALU, transaction model and
// per-cycle compare, plus literal expectations. Honours DIV0_TRAP_EN like the DUT.
`timescale 1ns/1ps

module tb_ac_writeback_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, ac_clr, err_clr;
  logic [2:0]  cmd_op, alu_op;
  logic [15:0] cmd_operand, alu_in_bus, alu_in_ac, alu_result, ac_out;
  logic        done, zero, err;

  int total = 0;
  int bad   = 0;

  ac_writeback_ctrl #(.DATA_W(16), .AC_RST(16'h0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand), .ac_clr(ac_clr), .err_clr(err_clr),
    .alu_op(alu_op), .alu_in_bus(alu_in_bus), .alu_in_ac(alu_in_ac),
    .alu_result(alu_result), .ac_out(ac_out), .done(done), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; a zero divisor yields garbage the DUT must not pass through.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] b,
                                         input logic [15:0] a);
    logic [31:0] p;
    p = a * b;
    case (op)
      3'd1: return p[15:0];
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return (b == 0) ? 16'h1234 : a / b;
      3'd5: return (b == 0) ? 16'h4321 : a % b;
      default: return b;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_op, alu_in_bus, alu_in_ac);

  // Expected accumulator value after a command, straight from the arithmetic rules.
  function automatic logic [15:0] expect_ac(input logic [2:0] op, input logic [15:0] ac,
                                            input logic [15:0] b);
    int unsigned a32, b32;
    a32 = ac; b32 = b;
    case (op)
      3'd1: return 16'((a32 * b32) % 65536);
      3'd2: return 16'((a32 + b32) % 65536);
      3'd3: return 16'((a32 + 65536 - b32) % 65536);
      3'd4: return (b == 0) ? 16'hFFFF : 16'(a32 / b32);
      3'd5: return (b == 0) ? ac : 16'(a32 % b32);
      default: return b;
    endcase
  endfunction

  logic [15:0] m_ac, m_bus;
  logic [2:0]  m_op;
  bit          m_zero, m_done, m_err;
  int          m_phase;   // 0 waiting, 1 executing, 2 trapped

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ac = 0; m_zero = 1; m_done = 0; m_err = 0; m_phase = 0; m_op = 0; m_bus = 0;
    end else begin
      m_done = 0;
      if (m_phase == 0) begin
        if (ac_clr) begin
          m_ac = 0; m_zero = 1;
        end else if (cmd_valid) begin
          m_op = cmd_op; m_bus = cmd_operand; m_phase = 1;
        end
      end else if (m_phase == 1) begin
`ifdef DIV0_TRAP_EN
        if ((m_op == 4 || m_op == 5) && m_bus == 0) begin
          m_err = 1; m_phase = 2;
        end else
`endif
        begin
          m_ac = expect_ac(m_op, m_ac, m_bus);
          m_zero = (m_ac == 0); m_done = 1; m_phase = 0;
        end
      end else if (err_clr) begin
        m_err = 0; m_phase = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_ready", cmd_ready, (m_phase == 0) && !ac_clr);
    chk("cyc_ac", ac_out, m_ac);
    chk("cyc_in_ac", alu_in_ac, m_ac);
    chk("cyc_zero", zero, m_zero);
    chk("cyc_done", done, m_done);
    chk("cyc_err", err, m_err);
    chk("cyc_op", alu_op, m_op);
    chk("cyc_bus", alu_in_bus, m_bus);
  end

  // Issues one command and checks its two-cycle timing; leaves time at the done negedge.
  task automatic do_cmd(input logic [2:0] op, input logic [15:0] v);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_operand = v;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    chk("exec_ready_low", cmd_ready, 0);
    chk("exec_no_done", done, 0);
    @(negedge clk);
`ifdef DIV0_TRAP_EN
    if ((op == 4 || op == 5) && v == 0) begin
      chk("trap_err", err, 1);
      chk("trap_no_done", done, 0);
    end else
`endif
    begin
      chk("wb_done", done, 1);
      chk("wb_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; cmd_valid = 0; ac_clr = 0; err_clr = 0; cmd_op = 0; cmd_operand = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ac", ac_out, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 rst_n = 1;

    do_cmd(3'd0, 16'd5);    chk("lit_pass5", ac_out, 5);
    do_cmd(3'd2, 16'd7);    chk("lit_add7", ac_out, 12); chk("lit_add7_zero", zero, 0);
    do_cmd(3'd3, 16'd12);   chk("lit_sub12", ac_out, 0); chk("lit_sub12_zero", zero, 1);
    do_cmd(3'd0, 16'd300);
    do_cmd(3'd1, 16'd300);  chk("lit_mul_trunc", ac_out, 24464);
    do_cmd(3'd0, 16'd100);
    do_cmd(3'd4, 16'd7);    chk("lit_div7", ac_out, 14);
    do_cmd(3'd0, 16'd100);
    do_cmd(3'd5, 16'd7);    chk("lit_mod7", ac_out, 2);
    do_cmd(3'd6, 16'd9);    chk("lit_op6", ac_out, 9);
    do_cmd(3'd7, 16'd0);    chk("lit_op7_zero", zero, 1);

    do_cmd(3'd0, 16'd50);
    do_cmd(3'd4, 16'd0);
`ifdef DIV0_TRAP_EN
    repeat (3) @(negedge clk);
    chk("trap_hold_ac", ac_out, 50);
    chk("trap_hold_ready", cmd_ready, 0);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
    @(negedge clk);
    chk("trap_cleared_err", err, 0);
    chk("trap_cleared_ready", cmd_ready, 1);
`else
    chk("lit_div0", ac_out, 16'hFFFF);
    do_cmd(3'd0, 16'd50);
    do_cmd(3'd5, 16'd0);    chk("lit_mod0", ac_out, 50);
    @(posedge clk); #1 err_clr = 1;
    @(posedge clk); #1 err_clr = 0;
`endif

    do_cmd(3'd0, 16'd33);
    @(posedge clk); #1;
    cmd_valid = 1; ac_clr = 1; cmd_op = 3'd0; cmd_operand = 16'd77;
    @(negedge clk); chk("clr_ready_low", cmd_ready, 0);
    @(posedge clk); #1 cmd_valid = 0; ac_clr = 0;
    @(negedge clk);
    chk("clr_ac", ac_out, 0);
    chk("clr_not_accepted", cmd_ready, 1);
    @(negedge clk); chk("clr_no_done", done, 0);

    // ac_clr must be ignored while a command executes
    do_cmd(3'd0, 16'd40);
    @(posedge clk); #1 cmd_valid = 1; cmd_op = 3'd2; cmd_operand = 16'd2;
    @(posedge clk); #1 cmd_valid = 0; ac_clr = 1;
    @(posedge clk); #1 ac_clr = 0;
    @(negedge clk); chk("exec_ignores_clr", ac_out, 42);

    @(posedge clk); #1 cmd_valid = 1; cmd_op = 3'd2; cmd_operand = 16'd5;
    @(posedge clk); #1 cmd_valid = 0;
    #2 rst_n = 0;
    @(negedge clk); chk("rst_exec_ac", ac_out, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("rst_exec_no_done", done, 0);
    @(negedge clk); chk("rst_exec_no_done2", done, 0); chk("rst_exec_ac2", ac_out, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
